// File: rtl/lock_attempt_ctrl.sv
// Attempt controller for the lock FSM: captures password/attempt codes, drives the match flag,
// counts consecutive failed attempts and imposes a timed lockout that blocks the enter button.
module lock_attempt_ctrl #(
  parameter  int W              = 4,
  parameter  int MAX_FAILS      = 3,
  parameter  int LOCKOUT_CYCLES = 50_000_000,
  localparam int FW             = $clog2(MAX_FAILS + 1),
  localparam int CW             = $clog2(LOCKOUT_CYCLES)
) (
  input  logic          CLK50,
  input  logic          reset,
  input  logic [W-1:0]  SW,
  input  logic          E_in,
  input  logic          savePW,
  input  logic          saveAT,
  input  logic          LOCKED,
  output logic          E_out,
  output logic          M,
  output logic          ALARM,
  output logic [FW-1:0] FAILS
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOCKOUT = 2'b01,
    REARM   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [FW-1:0] MAXF = FW'(MAX_FAILS);

  state_t        state, state_next;
  logic [W-1:0]  pw_reg, at_reg;
  logic          saveAT_d, savePW_d;
  logic [FW-1:0] fails, fails_next, fails_inc;
  logic [CW-1:0] lock_cnt, lock_cnt_next;
  logic          at_fall, pw_rise;

  // The lock state only matters to the FSM; it deliberately does not gate the enter button.
  logic unused_locked;
  assign unused_locked = LOCKED;

  assign M         = (at_reg == pw_reg);
  assign FAILS     = fails;
  assign at_fall   = saveAT_d & ~saveAT;
  assign pw_rise   = savePW & ~savePW_d;
  assign fails_inc = (fails == MAXF) ? fails : fails + FW'(1);

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    fails_next    = fails;
    E_out         = E_in;
    ALARM         = 1'b0;

    if (pw_rise)      fails_next = '0;
    else if (at_fall) fails_next = M ? '0 : fails_inc;

    case (state)
      IDLE: begin
        if (at_fall && !M && !pw_rise && (fails_inc == MAXF)) begin
          state_next    = LOCKOUT;
          lock_cnt_next = CW'(LOCKOUT_CYCLES - 1);
        end
      end
      LOCKOUT: begin
        E_out = 1'b0;
        ALARM = 1'b1;
        if (lock_cnt == '0) begin
          fails_next = '0;
          state_next = REARM;
        end else begin
          lock_cnt_next = lock_cnt - CW'(1);
        end
      end
      REARM: begin
        // Wait for a release so a button held through the lockout is not seen as a press.
        E_out = 1'b0;
        if (!E_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK50) begin
    if (reset) begin
      state    <= IDLE;
      pw_reg   <= '0;
      at_reg   <= '0;
      saveAT_d <= 1'b0;
      savePW_d <= 1'b0;
      fails    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      saveAT_d <= saveAT;
      savePW_d <= savePW;
      fails    <= fails_next;
      lock_cnt <= lock_cnt_next;
      if (savePW) pw_reg <= SW;
      if (saveAT) at_reg <= SW;
    end
  end

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
module tb_lock_attempt_ctrl;

  logic       CLK50 = 1'b0;
  logic       reset;
  logic [3:0] SW;
  logic       E_in, savePW, saveAT, LOCKED;
  logic       E_out, M, ALARM;
  logic [1:0] FAILS;

  int checks   = 0;
  int failures = 0;

  lock_attempt_ctrl #(.W(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(5)) dut (
    .CLK50 (CLK50),
    .reset (reset),
    .SW    (SW),
    .E_in  (E_in),
    .savePW(savePW),
    .saveAT(saveAT),
    .LOCKED(LOCKED),
    .E_out (E_out),
    .M     (M),
    .ALARM (ALARM),
    .FAILS (FAILS)
  );

  always #5 CLK50 = ~CLK50;

  task automatic check(input string nm, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: M=%0d ALARM=%0d E_out=%0d FAILS=%0d", nm, M, ALARM, E_out, FAILS);
    end
  endtask

  task automatic cyc(input string nm, input int m, input int a, input int e, input int f);
    #4;
    check(nm, (m < 0 || int'(M) == m) && (a < 0 || int'(ALARM) == a) &&
              (e < 0 || int'(E_out) == e) && (f < 0 || int'(FAILS) == f));
    @(posedge CLK50);
    #1;
  endtask

  task automatic attempt(input logic [3:0] code, input string tag, input int f_now, input int m_drop);
    SW     = code;
    saveAT = 1'b1;
    cyc({tag, "_a1"}, -1, 0, -1, f_now);
    cyc({tag, "_a2"}, -1, 0, -1, f_now);
    saveAT = 1'b0;
    cyc({tag, "_drop"}, m_drop, 0, -1, f_now);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; SW = 4'h0; E_in = 1'b0; savePW = 1'b0; saveAT = 1'b0; LOCKED = 1'b0;
    @(posedge CLK50); #1;
    @(posedge CLK50); #1;
    reset = 1'b0;

    check("rst_m", M == 1'b1);
    check("rst_alarm", ALARM == 1'b0);
    check("rst_fails", FAILS == 2'd0);
    cyc("rst_e0", 1, 0, 0, 0);
    E_in = 1'b1;
    #1;
    check("rst_e_follow", E_out == E_in);
    cyc("rst_e1", 1, 0, 1, 0);
    E_in = 1'b0;

    SW = 4'hA; savePW = 1'b1; LOCKED = 1'b1;
    cyc("pw_c1", 1, 0, 0, 0);
    cyc("pw_c2", 0, 0, 0, 0);
    cyc("pw_c3", 0, 0, 0, 0);
    savePW = 1'b0;
    cyc("pw_done", 0, 0, 0, 0);
    attempt(4'hA, "ok", 0, 1);
    cyc("ok_after", 1, 0, 0, 0);

    attempt(4'h3, "bad1", 0, 0);
    cyc("bad1_after", 0, 0, 0, 1);
    attempt(4'h3, "bad2", 1, 0);
    cyc("bad2_after", 0, 0, 0, 2);
    attempt(4'h3, "bad3", 2, 0);
    E_in = 1'b1;
    #1;
    check("lock_alarm", ALARM == 1'b1);
    check("lock_eblock", E_out == 1'b0);
    check("lock_fails", FAILS == 2'd3);
    cyc("lock_l1", 0, 1, 0, 3);
    cyc("lock_l2", 0, 1, 0, 3);
    cyc("lock_l3", 0, 1, 0, 3);
    cyc("lock_l4", 0, 1, 0, 3);
    cyc("lock_l5", 0, 1, 0, 3);

    cyc("rearm_r1", 0, 0, 0, 0);
    cyc("rearm_r2", 0, 0, 0, 0);
    cyc("rearm_r3", 0, 0, 0, 0);
    cyc("rearm_r4", 0, 0, 0, 0);
    E_in = 1'b0;
    cyc("rearm_release", 0, 0, 0, 0);
    E_in = 1'b1;
    #1;
    check("idle_e_follow", E_out == 1'b1);
    cyc("idle_press", 0, 0, 1, 0);
    E_in = 1'b0;
    cyc("idle_release", 0, 0, 0, 0);

    attempt(4'h3, "f1", 0, 0);
    cyc("f1_after", 0, 0, 0, 1);
    attempt(4'h3, "f2", 1, 0);
    cyc("f2_after", 0, 0, 0, 2);
    attempt(4'hA, "good", 2, 1);
    cyc("good_after", 1, 0, 0, 0);
    attempt(4'h3, "f3", 0, 0);
    cyc("f3_after", 0, 0, 0, 1);
    SW = 4'hA; savePW = 1'b1;
    cyc("pwrise", -1, 0, 0, 1);
    check("pwrise_cleared", FAILS == 2'd0);
    cyc("pwrise_after", 0, 0, 0, 0);
    savePW = 1'b0;
    cyc("pwrise_done", 0, 0, 0, 0);

    attempt(4'h3, "r1", 0, 0);
    cyc("r1_after", 0, 0, 0, 1);
    attempt(4'h3, "r2", 1, 0);
    cyc("r2_after", 0, 0, 0, 2);
    attempt(4'h3, "r3", 2, 0);
    E_in = 1'b1;
    cyc("rlock_l1", 0, 1, 0, 3);
    reset = 1'b1;
    cyc("rlock_l2", 0, 1, 0, 3);
    reset = 1'b0;
    check("post_reset_alarm", ALARM == 1'b0);
    check("post_reset_m", M == 1'b1);
    cyc("post_reset", 1, 0, 1, 0);
    cyc("post_reset2", 1, 0, 1, 0);
    E_in = 1'b0;
    cyc("post_reset3", 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
